// File: rtl/ipd_stage_if.sv
// IF/IPD/ID handshake bundle for the pre-decode stage.
// The stage takes the slave view; the environment (IF + ID side) takes the master view.
interface ipd_stage_if #(
    parameter int IN_WD  = 64,
    parameter int OUT_WD = 101
);
    logic [IN_WD-1:0]  IF_to_IPD_bus;
    logic              IF_to_IPD_valid;
    logic              IPD_allow_in;
    logic [OUT_WD-1:0] IPD_to_ID_bus;
    logic              IPD_to_ID_valid;
    logic              ID_allow_in;
    logic              br_taken_cancel;

    modport master (
        output IF_to_IPD_bus, IF_to_IPD_valid, ID_allow_in, br_taken_cancel,
        input  IPD_allow_in, IPD_to_ID_bus, IPD_to_ID_valid
    );

    modport slave (
        input  IF_to_IPD_bus, IF_to_IPD_valid, ID_allow_in, br_taken_cancel,
        output IPD_allow_in, IPD_to_ID_bus, IPD_to_ID_valid
    );
endinterface

// File: rtl/ipd_stage.sv
// Instruction pre-decode stage: 2-entry FIFO between IF and ID that tags each
// instruction with LA32R branch/memory class flags and its direct branch target.
module ipd_stage #(
    parameter int IN_WD  = 64,
    parameter int OUT_WD = 101
) (
    input  logic       clk,
    input  logic       reset,
    ipd_stage_if.slave bus_if
);
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  op6;
    logic [9:0]  op10;
    logic        is_br;
    logic        is_jirl;
    logic        is_direct;
    logic        is_load;
    logic        is_store;
    logic [31:0] br_target;
    logic [OUT_WD-1:0] dec_pkt;

    assign pc4  = bus_if.IF_to_IPD_bus[63:32];
    assign inst = bus_if.IF_to_IPD_bus[31:0];
    assign pc   = pc4 - 32'd4;
    assign op6  = inst[31:26];
    assign op10 = inst[31:22];

    always_comb begin
        is_direct = (op6 == 6'h14) || (op6 == 6'h15);
        is_jirl   = (op6 == 6'h13);
        is_br     = (op6 >= 6'h13) && (op6 <= 6'h1B);
        is_load   = op10 inside {10'h0A0, 10'h0A1, 10'h0A2, 10'h0A8, 10'h0A9};
        is_store  = op10 inside {10'h0A4, 10'h0A5, 10'h0A6};
        br_target = 32'd0;
        // JIRL stays 0: its target depends on a register value only ID has.
        if (is_direct) begin
            br_target = pc + {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
        end else if ((op6 >= 6'h16) && (op6 <= 6'h1B)) begin
            br_target = pc + {{14{inst[25]}}, inst[25:10], 2'b00};
        end
    end

    assign dec_pkt = {is_br, is_jirl, is_direct, is_load, is_store, br_target, pc, inst};

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       push;
    logic       pop;
    logic [OUT_WD-1:0] entry [2];

    assign bus_if.IPD_allow_in    = (count_q != 2'd2);
    assign bus_if.IPD_to_ID_valid = (count_q != 2'd0);
    assign bus_if.IPD_to_ID_bus   = entry[rd_ptr_q];

    assign push = bus_if.IF_to_IPD_valid & bus_if.IPD_allow_in & ~bus_if.br_taken_cancel;
    assign pop  = bus_if.IPD_to_ID_valid & bus_if.ID_allow_in & ~bus_if.br_taken_cancel;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus_if.br_taken_cancel) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + 2'(push) - 2'(pop);
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entries are cleared on reset so the bus reads 0 until the first push.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [OUT_WD-1:0] slot_q;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    slot_q <= '0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    slot_q <= dec_pkt;
                end
            end
            assign entry[gi] = slot_q;
        end
    endgenerate
endmodule

// File: tb/tb_ipd_stage.sv
// Self-checking bench for ipd_stage: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model of the stage.
module tb_ipd_stage;
    logic clk;
    logic reset;
    int   checks;
    int   passes;
    bit   model_live;
    logic [100:0] q[$];

    ipd_stage_if #(.IN_WD(64), .OUT_WD(101)) bus_if ();

    ipd_stage #(.IN_WD(64), .OUT_WD(101)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [100:0] predecode(input logic [63:0] b);
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] tgt;
        int          op6;
        int          op10;
        int          off;
        bit          br, jirl, direct, ld, st;
        inst   = b[31:0];
        pc     = b[63:32] - 32'd4;
        op6    = int'(inst[31:26]);
        op10   = int'(inst[31:22]);
        direct = (op6 == 20) || (op6 == 21);
        jirl   = (op6 == 19);
        br     = (op6 >= 19) && (op6 <= 27);
        ld     = (op10 == 160) || (op10 == 161) || (op10 == 162) || (op10 == 168) || (op10 == 169);
        st     = (op10 == 164) || (op10 == 165) || (op10 == 166);
        tgt    = 32'd0;
        if (direct) begin
            off = int'({inst[9:0], inst[25:10]});
            if (off >= (1 << 25)) off = off - (1 << 26);
            tgt = pc + 32'(off * 4);
        end else if (op6 >= 22 && op6 <= 27) begin
            off = int'(inst[25:10]);
            if (off >= 32768) off = off - 65536;
            tgt = pc + 32'(off * 4);
        end
        return {br, jirl, direct, ld, st, tgt, pc, inst};
    endfunction

    task automatic chk(input string name, input logic [100:0] act, input logic [100:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // Model: FIFO of already-decoded packets, updated with the same edge semantics as the stage.
    always @(posedge clk) begin
        bit do_push, do_pop;
        if (!reset) begin
            q.delete();
            model_live = 1'b1;
        end else if (bus_if.br_taken_cancel) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && bus_if.ID_allow_in;
            do_push = bus_if.IF_to_IPD_valid && (q.size() < 2);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(predecode(bus_if.IF_to_IPD_bus));
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("allow_in", 101'(bus_if.IPD_allow_in), 101'(q.size() != 2));
            chk("valid", 101'(bus_if.IPD_to_ID_valid), 101'(q.size() != 0));
            if (q.size() != 0) chk("head_bus", bus_if.IPD_to_ID_bus, q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] p);
        bus_if.IF_to_IPD_bus   = p;
        bus_if.IF_to_IPD_valid = 1'b1;
        step();
        bus_if.IF_to_IPD_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand_pkt();
        logic [31:0] inst;
        logic [31:0] pc4;
        inst = $urandom;
        pc4  = $urandom;
        case ($urandom_range(0, 3))
            0: inst[31:26] = 6'($urandom_range(19, 27));
            1: begin
                case ($urandom_range(0, 7))
                    0: inst[31:22] = 10'h0A0;
                    1: inst[31:22] = 10'h0A1;
                    2: inst[31:22] = 10'h0A2;
                    3: inst[31:22] = 10'h0A8;
                    4: inst[31:22] = 10'h0A9;
                    5: inst[31:22] = 10'h0A4;
                    6: inst[31:22] = 10'h0A5;
                    default: inst[31:22] = 10'h0A6;
                endcase
            end
            default: ;
        endcase
        return {pc4, inst};
    endfunction

    initial begin
        checks = 0;
        passes = 0;
        model_live = 1'b0;
        reset = 1'b0;
        bus_if.IF_to_IPD_bus   = '0;
        bus_if.IF_to_IPD_valid = 1'b0;
        bus_if.ID_allow_in     = 1'b0;
        bus_if.br_taken_cancel = 1'b0;
        step();
        step();
        chk("rst_valid", 101'(bus_if.IPD_to_ID_valid), 101'(0));
        chk("rst_bus", bus_if.IPD_to_ID_bus, 101'(0));
        chk("rst_allow", 101'(bus_if.IPD_allow_in), 101'(1));
        reset = 1'b1;

        // B +16
        send({32'h1C000004, 32'h50001000});
        chk("t1_valid", 101'(bus_if.IPD_to_ID_valid), 101'(1));
        chk("t1_pc", 101'(bus_if.IPD_to_ID_bus[63:32]), 101'(32'h1C000000));
        chk("t1_is_br", 101'(bus_if.IPD_to_ID_bus[100]), 101'(1));
        chk("t1_is_direct", 101'(bus_if.IPD_to_ID_bus[98]), 101'(1));
        chk("t1_target", 101'(bus_if.IPD_to_ID_bus[95:64]), 101'(32'h1C000010));
        bus_if.ID_allow_in = 1'b1;
        step();
        bus_if.ID_allow_in = 1'b0;

        // BEQ with offset -1
        send({32'h1C000104, 32'h5BFFFC00});
        chk("t2_is_br", 101'(bus_if.IPD_to_ID_bus[100]), 101'(1));
        chk("t2_is_direct", 101'(bus_if.IPD_to_ID_bus[98]), 101'(0));
        chk("t2_target", 101'(bus_if.IPD_to_ID_bus[95:64]), 101'(32'h1C0000FC));
        bus_if.ID_allow_in = 1'b1;
        step();
        bus_if.ID_allow_in = 1'b0;

        // Fill to full, C held by IF until accepted
        bus_if.IF_to_IPD_valid = 1'b1;
        bus_if.IF_to_IPD_bus = {32'h00001004, 32'h00000011};
        step();
        bus_if.IF_to_IPD_bus = {32'h00001008, 32'h00000022};
        step();
        bus_if.IF_to_IPD_bus = {32'h0000100C, 32'h00000033};
        step();
        chk("t3_full", 101'(bus_if.IPD_allow_in), 101'(0));
        step();
        chk("t3_head_A", 101'(bus_if.IPD_to_ID_bus[31:0]), 101'(32'h00000011));
        bus_if.ID_allow_in = 1'b1;
        step();
        chk("t3_reopen", 101'(bus_if.IPD_allow_in), 101'(1));
        chk("t3_head_B", 101'(bus_if.IPD_to_ID_bus[31:0]), 101'(32'h00000022));
        step();
        bus_if.IF_to_IPD_valid = 1'b0;
        chk("t3_head_C", 101'(bus_if.IPD_to_ID_bus[31:0]), 101'(32'h00000033));
        step();
        chk("t3_drained", 101'(bus_if.IPD_to_ID_valid), 101'(0));

        // Steady stream
        bus_if.IF_to_IPD_valid = 1'b1;
        bus_if.IF_to_IPD_bus = rand_pkt();
        step();
        for (int i = 0; i < 10; i++) begin
            bus_if.IF_to_IPD_bus = rand_pkt();
            step();
            chk("t4_valid", 101'(bus_if.IPD_to_ID_valid), 101'(1));
            chk("t4_allow", 101'(bus_if.IPD_allow_in), 101'(1));
        end
        bus_if.IF_to_IPD_valid = 1'b0;
        step();

        // Flush while full with a push pending
        bus_if.ID_allow_in = 1'b0;
        send({32'h00002004, 32'h00000044});
        send({32'h00002008, 32'h00000055});
        bus_if.IF_to_IPD_bus = {32'h0000200C, 32'h00000066};
        bus_if.IF_to_IPD_valid = 1'b1;
        bus_if.br_taken_cancel = 1'b1;
        step();
        bus_if.br_taken_cancel = 1'b0;
        bus_if.IF_to_IPD_valid = 1'b0;
        chk("t5_valid", 101'(bus_if.IPD_to_ID_valid), 101'(0));
        chk("t5_allow", 101'(bus_if.IPD_allow_in), 101'(1));
        send({32'h1C008004, 32'h00000077});
        chk("t5_next_valid", 101'(bus_if.IPD_to_ID_valid), 101'(1));
        chk("t5_next_pc", 101'(bus_if.IPD_to_ID_bus[63:32]), 101'(32'h1C008000));
        bus_if.ID_allow_in = 1'b1;
        step();

        // Memory classes and JIRL
        send({32'h1C000204, 32'h28800000});
        chk("t6_ld_load", 101'(bus_if.IPD_to_ID_bus[97]), 101'(1));
        chk("t6_ld_store", 101'(bus_if.IPD_to_ID_bus[96]), 101'(0));
        step();
        send({32'h1C000208, 32'h29800000});
        chk("t6_st_store", 101'(bus_if.IPD_to_ID_bus[96]), 101'(1));
        chk("t6_st_br", 101'(bus_if.IPD_to_ID_bus[100]), 101'(0));
        step();
        send({32'h1C00020C, 32'h4C000000});
        chk("t6_jirl", 101'(bus_if.IPD_to_ID_bus[99]), 101'(1));
        chk("t6_jirl_br", 101'(bus_if.IPD_to_ID_bus[100]), 101'(1));
        chk("t6_jirl_target", 101'(bus_if.IPD_to_ID_bus[95:64]), 101'(0));
        step();
        bus_if.ID_allow_in = 1'b0;
        send(rand_pkt());
        send(rand_pkt());
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_rst_valid", 101'(bus_if.IPD_to_ID_valid), 101'(0));
        chk("t6_rst_bus", bus_if.IPD_to_ID_bus, 101'(0));
        chk("t6_rst_allow", 101'(bus_if.IPD_allow_in), 101'(1));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus_if.IF_to_IPD_bus   = rand_pkt();
            bus_if.IF_to_IPD_valid = ($urandom_range(0, 3) != 0);
            bus_if.ID_allow_in     = ($urandom_range(0, 2) != 0);
            bus_if.br_taken_cancel = ($urandom_range(0, 24) == 0);
            reset                  = ($urandom_range(0, 149) != 0);
            step();
        end
        reset = 1'b1;
        bus_if.IF_to_IPD_valid = 1'b0;
        bus_if.br_taken_cancel = 1'b0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
